data_ram_bank: RTL and testbench

- Parametrised single-port data RAM for the CPU data path, with byte-strobe writes and bounds/alignment checking.
- Uses a request/response handshake with a configurable, fixed read latency.
- Sits between the memory stage and the backing storage.
- Every accepted request gets exactly one in-order response.

---
 rtl/data_ram_pkg.sv | 38 +++
 rtl/data_ram_resp_pipe.sv | 32 +++
 rtl/data_ram_bank.sv | 140 ++++++++++++++
 tb/tb_data_ram_bank.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_ram_pkg.sv
// Shared types and helpers for the data RAM bank: width derivation, response record, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package data_ram_pkg;

    localparam int READ_LATENCY_MAX = 4;
    // Response records carry the widest supported word; narrower banks use the low bits.
    localparam int DATA_WIDTH_MAX   = 256;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int addr_lsb(input int data_width);
        return clog2(data_width / 8);
    endfunction

    typedef struct packed {
        logic                      valid;
        logic                      err;
        logic [DATA_WIDTH_MAX-1:0] rdata;
    } resp_t;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } clear_state_t;

endpackage

// File: rtl/data_ram_resp_pipe.sv
// Fixed-depth response delay line between the array and the response port.
// Latency: LATENCY cycles from next_resp to resp.
// Backpressure: none; advances every cycle, clr drops everything in flight.
module data_ram_resp_pipe
    import data_ram_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic  clk,
    input  logic  clr,
    input  resp_t next_resp,
    output resp_t resp
);

    resp_t stage [LATENCY];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= next_resp;
            for (int i = 1; i < LATENCY; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign resp = stage[LATENCY-1];

endmodule

// File: rtl/data_ram_bank.sv
// Single-port data RAM with byte strobes, range/alignment checks; DATA_RAM_CLEAR_ON_RESET_EN zeroes the array after reset.
// Latency: response READ_LATENCY cycles after accept, one response per request, in order.
// Backpressure: req_ready low only in reset (and during clear); no response backpressure.
module data_ram_bank
    import data_ram_pkg::*;
#(
    parameter int          DATA_WIDTH   = 32,
    parameter int          DEPTH_WORDS  = 65536,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    input  logic [31:0]             req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err
);

    localparam int          BYTES    = bytes_per_word(DATA_WIDTH);
    localparam int          ADDR_LSB = addr_lsb(DATA_WIDTH);
    localparam int          IDX_W    = clog2(DEPTH_WORDS);
    localparam longint      SPAN     = longint'(DEPTH_WORDS) * longint'(BYTES);
    localparam logic [31:0] LSB_MASK = 32'(BYTES - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    logic [31:0]      off;
    logic [IDX_W-1:0] idx;
    logic             out_of_range;
    logic             misaligned;
    logic             addr_err;
    logic             accept;
    logic             wr_fire;
    resp_t            next_resp;
    resp_t            pipe_resp;
    logic             unused_rdata_hi;

    // Wrapping subtraction: addresses below BASE_ADDR land far past the span and fail the range test.
    assign off          = req_addr - BASE_ADDR;
    assign out_of_range = {1'b0, off} >= 33'(SPAN);
    assign misaligned   = |(off & LSB_MASK);
    assign addr_err     = out_of_range || misaligned;
    assign idx          = off[ADDR_LSB +: IDX_W];

    assign accept  = req_valid && req_ready;
    assign wr_fire = accept && req_we && !addr_err;

`ifdef DATA_RAM_CLEAR_ON_RESET_EN
    clear_state_t     state;
    logic [IDX_W-1:0] clear_idx;
    logic             rdy_q;
    logic             clear_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_CLEAR;
            clear_idx <= '0;
            rdy_q     <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clear_idx == IDX_W'(DEPTH_WORDS - 1)) begin
                        state <= ST_RUN;
                        rdy_q <= 1'b1;
                    end else begin
                        clear_idx <= clear_idx + IDX_W'(1);
                    end
                end
                ST_RUN: begin
                    rdy_q <= 1'b1;
                end
                default: begin
                    state <= ST_CLEAR;
                    rdy_q <= 1'b0;
                end
            endcase
        end
    end

    assign clear_we  = (state == ST_CLEAR) && !rst;
    assign req_ready = rdy_q && !rst;

    // Requests are refused while clearing, so the two write sources never collide.
    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem[clear_idx] <= '0;
        end
        if (wr_fire) begin
            for (int b = 0; b < BYTES; b++) begin
                if (req_wstrb[b]) begin
                    mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end
`else
    assign req_ready = !rst;

    // No reset term: contents persist across reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int b = 0; b < BYTES; b++) begin
                if (req_wstrb[b]) begin
                    mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end
`endif

    always_comb begin
        next_resp       = '0;
        next_resp.valid = accept;
        next_resp.err   = accept && addr_err;
        if (accept && !req_we && !addr_err) begin
            next_resp.rdata[DATA_WIDTH-1:0] = mem[idx];
        end
    end

    data_ram_resp_pipe #(
        .LATENCY (READ_LATENCY)
    ) u_resp_pipe (
        .clk       (clk),
        .clr       (rst),
        .next_resp (next_resp),
        .resp      (pipe_resp)
    );

    assign resp_valid      = pipe_resp.valid;
    assign resp_err        = pipe_resp.err;
    assign resp_rdata      = pipe_resp.rdata[DATA_WIDTH-1:0];
    assign unused_rdata_hi = ^pipe_resp.rdata;

endmodule

// File: tb/tb_data_ram_bank.sv
// Scoreboard bench for data_ram_bank: directed requests push expected responses, a negedge monitor pops and compares.
module tb_data_ram_bank;

    localparam int          DW   = 32;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          RL   = 3;
`ifdef DATA_RAM_CLEAR_ON_RESET_EN
    localparam int          DEPTH     = 16;
    localparam int          CLEAR_CYC = 16;
`else
    localparam int          DEPTH     = 1024;
    localparam int          CLEAR_CYC = 0;
`endif
    localparam logic [31:0] LAST_ADDR = BASE + 32'(DEPTH * 4) - 32'd4;
    localparam logic [31:0] END_ADDR  = BASE + 32'(DEPTH * 4);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [3:0]    req_wstrb = 4'h0;
    logic [31:0]   req_addr = 32'h0;
    logic [DW-1:0] req_wdata = '0;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;

    data_ram_bank #(
        .DATA_WIDTH   (DW),
        .DEPTH_WORDS  (DEPTH),
        .BASE_ADDR    (BASE),
        .READ_LATENCY (RL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_wstrb  (req_wstrb),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Monitor: every response must match the head of the queue and arrive on its due edge.
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious resp_valid", {31'b0, resp_valid}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_err", {31'b0, resp_err}, {31'b0, mon_e.err});
                check("resp_rdata", resp_rdata, mon_e.rdata);
                check("resp latency edge", edge_cnt, mon_e.due);
            end
        end else if (exp_q.size() != 0 && exp_q[0].due <= edge_cnt) begin
            check("missing resp_valid", {31'b0, resp_valid}, 32'd1);
            void'(exp_q.pop_front());
        end
    end

    task automatic issue(input logic we, input logic [3:0] strb, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic exp_err,
                         input logic [31:0] exp_rdata, input bit track);
        exp_t e;
        @(negedge clk);
        check("req_ready at issue", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_wstrb = strb;
        req_addr  = addr;
        req_wdata = wdata;
        if (track) begin
            e.err   = exp_err;
            e.rdata = exp_rdata;
            e.due   = edge_cnt + RL;
            exp_q.push_back(e);
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                      input logic exp_err);
        issue(1'b1, strb, addr, data, exp_err, 32'h0, 1'b1);
    endtask

    task automatic rd(input logic [31:0] addr, input logic exp_err, input logic [31:0] exp_data);
        issue(1'b0, 4'h0, addr, 32'h0, exp_err, exp_data, 1'b1);
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain pending responses", exp_q.size(), 32'd0);
    endtask

    // Called right after rst drops at a negedge; counts cycles with req_ready low.
    task automatic wait_ready(input string name, input int exp_low);
        int n;
        n = 0;
        #1;
        while (req_ready !== 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check(name, n, exp_low);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
        rst       = 1'b1;
        #1;
        check("reset req_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        check("reset resp_valid", {31'b0, resp_valid}, 32'd0);
        check("reset resp_rdata", resp_rdata, 32'd0);
        check("reset resp_err", {31'b0, resp_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_ready("ready-low cycles after reset", CLEAR_CYC);
    endtask

    initial begin
        #200000;
        checks++;
        fails++;
        $display("FAIL global timeout: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        do_reset();

        // Full write then immediate read of the same word.
        wr(BASE + 32'h10, 32'hDEAD_BEEF, 4'b1111, 1'b0);
        rd(BASE + 32'h10, 1'b0, 32'hDEAD_BEEF);
        // Lanes 0 and 2 replaced, lanes 1 and 3 keep BE and DE.
        wr(BASE + 32'h10, 32'h00AA_00CC, 4'b0101, 1'b0);
        rd(BASE + 32'h10, 1'b0, 32'hDEAA_BECC);
        wr(BASE + 32'h10, 32'hFFFF_FFFF, 4'b0000, 1'b0);
        rd(BASE + 32'h10, 1'b0, 32'hDEAA_BECC);

        // Error cases; 0x2000 would alias word 0 if the offset were truncated.
        wr(BASE, 32'h1122_3344, 4'b1111, 1'b0);
        rd(32'h0000_0FFC, 1'b1, 32'h0);
        wr(32'h0000_2000, 32'h1234_5678, 4'b1111, 1'b1);
        wr(BASE + 32'h1, 32'h5566_7788, 4'b1111, 1'b1);
        rd(BASE, 1'b0, 32'h1122_3344);
        rd(32'h0000_1002, 1'b1, 32'h0);
        wr(LAST_ADDR, 32'hCAFE_F00D, 4'b1111, 1'b0);
        rd(LAST_ADDR, 1'b0, 32'hCAFE_F00D);
        rd(END_ADDR, 1'b1, 32'h0);

        // Back-to-back writes then eight back-to-back reads.
        for (int k = 0; k < 8; k++) begin
            wr(BASE + 32'h20 + 32'(4 * k), 32'h5000_0000 + 32'(k * 32'h111), 4'b1111, 1'b0);
        end
        for (int k = 0; k < 8; k++) begin
            rd(BASE + 32'h20 + 32'(4 * k), 1'b0, 32'h5000_0000 + 32'(k * 32'h111));
        end
        idle();
        drain();

`ifdef DATA_RAM_CLEAR_ON_RESET_EN
        for (int k = 0; k < DEPTH; k++) begin
            wr(BASE + 32'(4 * k), 32'h7700_0000 | 32'(k), 4'b1111, 1'b0);
        end
        idle();
        drain();
`endif

        // Two reads in flight, then reset: their responses must never appear.
        issue(1'b0, 4'h0, BASE + 32'h10, 32'h0, 1'b0, 32'h0, 1'b0);
        issue(1'b0, 4'h0, BASE + 32'h20, 32'h0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        rst       = 1'b1;
        check("flushed resp_valid A", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        check("flushed resp_valid B", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        check("flushed resp_valid C", {31'b0, resp_valid}, 32'd0);
        rst = 1'b0;
        wait_ready("ready-low cycles after mid-flight reset", CLEAR_CYC);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post-reset resp_valid", {31'b0, resp_valid}, 32'd0);
        end

`ifdef DATA_RAM_CLEAR_ON_RESET_EN
        for (int k = 0; k < DEPTH; k++) begin
            rd(BASE + 32'(4 * k), 1'b0, 32'h0);
        end
`else
        rd(BASE + 32'h10, 1'b0, 32'hDEAA_BECC);
        rd(BASE, 1'b0, 32'h1122_3344);
`endif
        idle();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
